ft_tx_arbiter: RTL and testbench

// Round-robin scheduler sharing the FT600/FT601 bridge write interface (ui_din*)

---
 rtl/ft_tx_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ft_tx_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft_tx_arbiter.sv
// ft_tx_arbiter
// Round-robin scheduler that shares the FT600/FT601 bridge TX write port among
// NUM_CH stream sources. Each grant produces one frame on the bridge:
//   header  {4'hA, chan, seq}   -> 0..MAX_BURST payload words -> trailer {4'h5, chan, count}
// The host demultiplexes channels from the header/trailer words.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_chan_en           per-channel enable (0 = never granted)
//   i_src_data/_be      per-channel payload and byte enables, channel i at slice i
//   i_src_valid/_last   per-channel word available / word ends the frame
//   o_src_ready         per-channel accept (word taken on valid & ready)
//   o_ui_din/_be/_valid bridge TX FIFO write port, i_ui_din_full back-pressure
//   o_busy              high whenever a frame is in progress
//   o_cur_chan          granted channel, holds the last grant while idle
//   o_frame_done        one-cycle pulse in the cycle the trailer is written
module ft_tx_arbiter #(
  parameter int BUS_WIDTH     = 16,
  parameter int NUM_CH        = 4,
  parameter int MAX_BURST     = 64,
  parameter int STALL_TIMEOUT = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_CH-1:0]             i_chan_en,
  input  logic [NUM_CH*BUS_WIDTH-1:0]   i_src_data,
  input  logic [NUM_CH*BUS_WIDTH/8-1:0] i_src_be,
  input  logic [NUM_CH-1:0]             i_src_valid,
  input  logic [NUM_CH-1:0]             i_src_last,
  output logic [NUM_CH-1:0]             o_src_ready,
  output logic [BUS_WIDTH-1:0]          o_ui_din,
  output logic [BUS_WIDTH/8-1:0]        o_ui_din_be,
  output logic                          o_ui_din_valid,
  input  logic                          i_ui_din_full,
  output logic                          o_busy,
  output logic [3:0]                    o_cur_chan,
  output logic                          o_frame_done
);

  localparam int BEW = BUS_WIDTH / 8;
  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SW  = $clog2(STALL_TIMEOUT + 1);
  localparam logic [7:0]    LAST_CNT  = 8'(MAX_BURST - 1);
  localparam logic [SW-1:0] LAST_IDLE = SW'(STALL_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_BURST, S_TRAILER} state_t;

  state_t                 r_state, w_next;
  logic [CW-1:0]          r_cur, r_rr;
  logic [NUM_CH-1:0][7:0] r_seq;
  logic [7:0]             r_count;
  logic [SW-1:0]          r_stall;

  logic [NUM_CH-1:0]      w_req;
  logic                   w_hit;
  logic [CW-1:0]          w_grant;
  logic [BUS_WIDTH-1:0]   w_src_word;
  logic [BEW-1:0]         w_src_be;
  logic                   w_src_vld, w_src_last;
  logic [15:0]            w_hdr, w_trl;
  logic                   w_pending, w_beat, w_idle;

  // Round-robin search from r_rr. Scanning from the far end down means the
  // last assignment wins, i.e. the lowest offset from the pointer.
  always_comb begin
    int idx;
    idx     = 0;
    w_req   = i_src_valid & i_chan_en;
    w_hit   = 1'b0;
    w_grant = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = (int'(r_rr) + k) % NUM_CH;
      if (w_req[idx]) begin
        w_hit   = 1'b1;
        w_grant = CW'(idx);
      end
    end
  end

  assign w_src_word = i_src_data[r_cur*BUS_WIDTH +: BUS_WIDTH];
  assign w_src_be   = i_src_be[r_cur*BEW +: BEW];
  assign w_src_vld  = i_src_valid[r_cur];
  assign w_src_last = i_src_last[r_cur];

  assign w_hdr = {4'hA, 4'(r_cur), r_seq[r_cur]};
  assign w_trl = {4'h5, 4'(r_cur), r_count};

  // A full FIFO is back-pressure, not a source stall: neither a beat nor an idle.
  assign w_beat = (r_state == S_BURST) &  w_src_vld & ~i_ui_din_full;
  assign w_idle = (r_state == S_BURST) & ~w_src_vld & ~i_ui_din_full;

  always_comb begin
    w_next      = r_state;
    w_pending   = 1'b0;
    o_ui_din    = '0;
    o_ui_din_be = '0;
    o_src_ready = '0;
    case (r_state)
      S_IDLE: begin
        if (w_hit) w_next = S_HEADER;
      end
      S_HEADER: begin
        w_pending   = 1'b1;
        o_ui_din    = BUS_WIDTH'(w_hdr);
        o_ui_din_be = '1;
        if (!i_ui_din_full) w_next = S_BURST;
      end
      S_BURST: begin
        w_pending          = w_src_vld;
        o_ui_din           = w_src_word;
        o_ui_din_be        = w_src_be;
        o_src_ready[r_cur] = ~i_ui_din_full;
        if (w_beat) begin
          if (w_src_last || r_count == LAST_CNT) w_next = S_TRAILER;
        end else if (w_idle && r_stall == LAST_IDLE) begin
          w_next = S_TRAILER;
        end
      end
      S_TRAILER: begin
        w_pending   = 1'b1;
        o_ui_din    = BUS_WIDTH'(w_trl);
        o_ui_din_be = '1;
        if (!i_ui_din_full) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_ui_din_valid = w_pending & ~i_ui_din_full;
  assign o_frame_done   = (r_state == S_TRAILER) & ~i_ui_din_full;
  assign o_busy         = (r_state != S_IDLE);
  assign o_cur_chan     = 4'(r_cur);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_rr    <= '0;
      r_seq   <= '0;
      r_count <= '0;
      r_stall <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_hit) r_cur <= w_grant;
        end
        S_HEADER: begin
          if (!i_ui_din_full) begin
            r_count <= '0;
            r_stall <= '0;
          end
        end
        S_BURST: begin
          if (w_beat) begin
            r_count <= r_count + 8'd1;
            r_stall <= '0;
          end else if (w_idle) begin
            r_stall <= r_stall + 1'b1;
          end
        end
        S_TRAILER: begin
          if (!i_ui_din_full) begin
            r_seq[r_cur] <= r_seq[r_cur] + 8'd1;
            r_rr         <= (r_cur == CW'(NUM_CH - 1)) ? '0 : CW'(r_cur + 1'b1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ft_tx_arbiter.sv
module tb_ft_tx_arbiter;
  localparam int NCH = 4, BW = 16, MAXB = 4, STO = 16;

  logic              clk, rst;
  logic [NCH-1:0]    chan_en, src_valid, src_last, src_ready;
  logic [NCH*BW-1:0] src_data;
  logic [NCH*2-1:0]  src_be;
  logic [BW-1:0]     din;
  logic [1:0]        din_be;
  logic              din_valid, full, busy, frame_done;
  logic [3:0]        cur_chan;

  ft_tx_arbiter #(.BUS_WIDTH(BW), .NUM_CH(NCH), .MAX_BURST(MAXB), .STALL_TIMEOUT(STO)) dut (
    .i_clk(clk), .i_rst(rst), .i_chan_en(chan_en), .i_src_data(src_data),
    .i_src_be(src_be), .i_src_valid(src_valid), .i_src_last(src_last),
    .o_src_ready(src_ready), .o_ui_din(din), .o_ui_din_be(din_be),
    .o_ui_din_valid(din_valid), .i_ui_din_full(full), .o_busy(busy),
    .o_cur_chan(cur_chan), .o_frame_done(frame_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_cmp, n_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- stream sources and frame-level reference model ----------
  logic [15:0] sd[NCH][64];
  logic [1:0]  sb[NCH][64];
  bit          sl[NCH][64];
  int          slen[NCH];
  logic [17:0] exp_q[$], cap[$];
  logic [7:0]  m_seq[NCH];
  int          m_rr, m_frames;

  // Frames built from the packet lists: round-robin over enabled channels that
  // still hold words, each frame cut at src_last or MAXB words.
  task automatic build_model(input logic [3:0] mask);
    int pos[NCH];
    int c, n, cc;
    bit found, lst;
    exp_q.delete();
    m_frames = 0;
    c = 0;
    for (int i = 0; i < NCH; i++) pos[i] = 0;
    forever begin
      found = 0;
      for (int k = 0; k < NCH; k++) begin
        cc = (m_rr + k) % NCH;
        if (!found && mask[cc] && pos[cc] < slen[cc]) begin
          found = 1;
          c = cc;
        end
      end
      if (!found) break;
      exp_q.push_back({2'b11, 4'hA, 4'(c), m_seq[c]});
      n = 0;
      lst = 0;
      while (!lst && n < MAXB && pos[c] < slen[c]) begin
        exp_q.push_back({sb[c][pos[c]], sd[c][pos[c]]});
        lst = sl[c][pos[c]];
        pos[c]++;
        n++;
      end
      exp_q.push_back({2'b11, 4'h5, 4'(c), 8'(n)});
      m_seq[c] = m_seq[c] + 8'd1;
      m_rr = (c + 1) % NCH;
      m_frames++;
    end
  endtask

  task automatic run_stream(input logic [3:0] mask, input int pct);
    int idx[NCH];
    int cyc, nfd;
    bit done;
    logic [3:0] hs;
    build_model(mask);
    cap.delete();
    nfd = 0; cyc = 0; done = 0;
    for (int c = 0; c < NCH; c++) idx[c] = 0;
    chan_en = mask;
    while (!done && cyc < 3000) begin
      for (int c = 0; c < NCH; c++) begin
        src_valid[c] = (idx[c] < slen[c]);
        if (src_valid[c]) begin
          src_data[c*BW +: BW] = sd[c][idx[c]];
          src_be[c*2 +: 2]     = sb[c][idx[c]];
          src_last[c]          = sl[c][idx[c]];
        end else begin
          src_data[c*BW +: BW] = '0;
          src_be[c*2 +: 2]     = '0;
          src_last[c]          = 1'b0;
        end
      end
      full = ($urandom_range(99) < pct);
      @(negedge clk);
      if (din_valid) begin
        cap.push_back({din_be, din});
        chk("no_write_when_full", full, 0);
      end
      if (frame_done) nfd++;
      hs = src_ready & src_valid;
      done = !busy;
      for (int c = 0; c < NCH; c++) if (mask[c] && idx[c] < slen[c]) done = 0;
      @(posedge clk); #1;
      for (int c = 0; c < NCH; c++) if (hs[c]) idx[c]++;
      cyc++;
    end
    src_valid = '0; src_last = '0; full = 1'b0;
    chk("stream_done", done, 1);
    chk("stream_len", cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < cap.size()) chk($sformatf("stream_word%0d", i), cap[i], exp_q[i]);
    chk("frame_done_count", nfd, m_frames);
  endtask

  task automatic clear_streams();
    for (int c = 0; c < NCH; c++) slen[c] = 0;
  endtask

  task automatic add_pkt(input int c, input int n, input logic [15:0] base, input logic [1:0] be);
    for (int i = 0; i < n; i++) begin
      sd[c][slen[c]] = base + 16'(i);
      sb[c][slen[c]] = be;
      sl[c][slen[c]] = (i == n - 1);
      slen[c]++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; src_valid = '0; src_last = '0; src_data = '0; src_be = '0;
    full = 1'b0; chan_en = 4'hF;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) m_seq[c] = 8'd0;
    m_rr = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", din_valid, 0);
    chk("rst_ready", src_ready, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_cur_chan", cur_chan, 0);
    @(posedge clk); #1;
  endtask

  // ---------------- cycle table -------------------------------------------
  typedef struct {
    int ch; bit v; bit l; logic [15:0] d; bit f;
    bit ev; bit cd; logic [15:0] ed; logic [3:0] er; bit efd; bit eb;
  } vec_t;
  vec_t tbl[$];

  task automatic addv(input int ch, input bit v, input bit l, input logic [15:0] d, input bit f,
                      input bit ev, input bit cd, input logic [15:0] ed, input logic [3:0] er,
                      input bit efd, input bit eb);
    vec_t r;
    r.ch = ch; r.v = v; r.l = l; r.d = d; r.f = f;
    r.ev = ev; r.cd = cd; r.ed = ed; r.er = er; r.efd = efd; r.eb = eb;
    tbl.push_back(r);
  endtask

  initial begin
    logic [15:0] hl[$];
    logic [15:0] hexp[$];
    int n2;
    n_cmp = 0; n_err = 0;
    rst = 1'b1; chan_en = '0; src_valid = '0; src_last = '0;
    src_data = '0; src_be = '0; full = 1'b0;
    repeat (2) @(posedge clk); #1;
    do_reset();

    // ch0 alone, 3 words
    //   ch v  l  data      f  ev cd ed         er    fd eb
    addv(0, 1, 0, 16'h1111, 0, 0, 0, 16'h0000, 4'h0, 0, 0);
    addv(0, 1, 0, 16'h1111, 0, 1, 1, 16'hA000, 4'h0, 0, 1);
    addv(0, 1, 0, 16'h1111, 0, 1, 1, 16'h1111, 4'h1, 0, 1);
    addv(0, 1, 0, 16'h2222, 0, 1, 1, 16'h2222, 4'h1, 0, 1);
    addv(0, 1, 1, 16'h3333, 0, 1, 1, 16'h3333, 4'h1, 0, 1);
    addv(0, 0, 0, 16'h0000, 0, 1, 1, 16'h5003, 4'h0, 1, 1);
    addv(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 4'h0, 0, 0);
    // ch3, FIFO full for 5 cycles mid-burst
    addv(3, 1, 0, 16'h4444, 0, 0, 0, 16'h0000, 4'h0, 0, 0);
    addv(3, 1, 0, 16'h4444, 0, 1, 1, 16'hA300, 4'h0, 0, 1);
    addv(3, 1, 0, 16'h4444, 0, 1, 1, 16'h4444, 4'h8, 0, 1);
    for (int i = 0; i < 5; i++)
      addv(3, 1, 0, 16'h5555, 1, 0, 1, 16'h5555, 4'h0, 0, 1);
    addv(3, 1, 0, 16'h5555, 0, 1, 1, 16'h5555, 4'h8, 0, 1);
    addv(3, 1, 1, 16'h6666, 0, 1, 1, 16'h6666, 4'h8, 0, 1);
    addv(3, 0, 0, 16'h0000, 0, 1, 1, 16'h5303, 4'h0, 1, 1);
    addv(3, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 4'h0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      src_valid = '0; src_last = '0; src_data = '0; src_be = '0; chan_en = 4'hF;
      src_valid[tbl[i].ch] = tbl[i].v;
      src_last[tbl[i].ch]  = tbl[i].l;
      src_data[tbl[i].ch*BW +: BW] = tbl[i].d;
      src_be[tbl[i].ch*2 +: 2] = 2'b11;
      full = tbl[i].f;
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), din_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_ready", i), src_ready, tbl[i].er);
      chk($sformatf("tbl%0d_frame_done", i), frame_done, tbl[i].efd);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
      if (tbl[i].cd) chk($sformatf("tbl%0d_din", i), din, tbl[i].ed);
      if (tbl[i].ev) chk($sformatf("tbl%0d_be", i), din_be, 2'b11);
      if (tbl[i].eb) chk($sformatf("tbl%0d_cur_chan", i), cur_chan, tbl[i].ch);
      @(posedge clk); #1;
    end

    // all four channels with 2-word frames: grant order 0,1,2,3,0
    do_reset();
    clear_streams();
    add_pkt(0, 2, 16'h1000, 2'b10);
    add_pkt(0, 2, 16'h1010, 2'b10);
    for (int c = 1; c < NCH; c++) add_pkt(c, 2, 16'(16'h1000 + c * 16'h100), 2'b10);
    run_stream(4'hF, 0);
    hl.delete();
    foreach (cap[i]) if (cap[i][17:16] == 2'b11 && cap[i][15:12] == 4'hA) hl.push_back(cap[i][15:0]);
    hexp = '{16'hA000, 16'hA100, 16'hA200, 16'hA300, 16'hA001};
    chk("rr_header_count", hl.size(), hexp.size());
    foreach (hexp[i]) if (i < hl.size()) chk($sformatf("rr_header%0d", i), hl[i], hexp[i]);

    // MAX_BURST split: ch2 streams 10 words, one src_last on the 10th
    do_reset();
    clear_streams();
    add_pkt(2, 10, 16'h2000, 2'b01);
    run_stream(4'hF, 0);
    hl.delete();
    foreach (cap[i]) if (cap[i][17:16] == 2'b11) hl.push_back(cap[i][15:0]);
    hexp = '{16'hA200, 16'h5204, 16'hA201, 16'h5204, 16'hA202, 16'h5202};
    chk("split_ctl_count", hl.size(), hexp.size());
    foreach (hexp[i]) if (i < hl.size()) chk($sformatf("split_ctl%0d", i), hl[i], hexp[i]);

    // ch1 stalls after 2 words: trailer right after the 16th idle cycle
    do_reset();
    src_valid[1] = 1'b1; src_data[1*BW +: BW] = 16'h1AAA; src_be[3:2] = 2'b11;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk); chk("stall_header", din, 16'hA100);
    @(posedge clk); #1;
    @(negedge clk); chk("stall_w0_valid", din_valid, 1);
    @(posedge clk); #1;
    src_data[1*BW +: BW] = 16'h1BBB;
    @(negedge clk); chk("stall_w1_valid", din_valid, 1);
    @(posedge clk); #1;
    src_valid = '0;
    for (int k = 1; k <= STO; k++) begin
      @(negedge clk);
      chk($sformatf("stall_idle%0d_valid", k), din_valid, 0);
      chk($sformatf("stall_idle%0d_busy", k), busy, 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("stall_trailer_valid", din_valid, 1);
    chk("stall_trailer", din, 16'h5102);
    chk("stall_frame_done", frame_done, 1);
    @(posedge clk); #1;

    // chan_en = 1011: ch2 has data but is never granted
    do_reset();
    clear_streams();
    for (int c = 0; c < NCH; c++)
      for (int p = 0; p < 3; p++) add_pkt(c, 1 + p, 16'(16'h3000 + c * 16'h100 + p * 16'h10), 2'b01);
    run_stream(4'b1011, 20);
    n2 = 0;
    foreach (cap[i]) if (cap[i][17:16] == 2'b11 && cap[i][11:8] == 4'h2) n2++;
    chk("masked_ch2_frames", n2, 0);

    // reset mid-burst: busy drops at once, sequence numbers restart
    do_reset();
    clear_streams();
    add_pkt(0, 2, 16'h0700, 2'b11);
    run_stream(4'hF, 0);
    chan_en = 4'hF;
    src_valid[0] = 1'b1; src_data[0 +: BW] = 16'h7777; src_be[1:0] = 2'b11; src_last[0] = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk); chk("rstmid_header", din, 16'hA001);
    @(posedge clk); #1;
    @(negedge clk); chk("rstmid_burst_busy", busy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_valid", din_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_new_header_valid", din_valid, 1);
    chk("rstmid_new_header", din, 16'hA000);
    @(posedge clk); #1;

    // randomized traffic against the frame-level model
    do_reset();
    for (int r = 0; r < 6; r++) begin
      clear_streams();
      for (int c = 0; c < NCH; c++) begin
        int n;
        n = $urandom_range(0, 12);
        for (int i = 0; i < n; i++) begin
          sd[c][i] = 16'($urandom);
          sb[c][i] = 2'($urandom);
          sl[c][i] = ($urandom_range(3) == 0) || (i == n - 1);
        end
        slen[c] = n;
      end
      run_stream(4'($urandom_range(1, 15)), 30);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
